// File: rtl/sa_ram_rd_stream.sv
// sa_ram_rd_stream: burst reader for a 1-cycle-latency RAM, streaming words out on valid/ready
// Ports: clk_i/rstn_i (sync active-low reset); cmd_valid_i/cmd_ready_o/cmd_addr_i/cmd_len_i burst
// command (len 0 = 2**AW beats); ra_o/re_o/dout_i RAM read port; out_valid_o/out_ready_i/
// out_data_o/out_last_o output stream.
module sa_ram_rd_stream #(
  parameter int AW = 7,
  parameter int DW = 64,
  parameter int BUF_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [AW-1:0] cmd_len_i,
  output logic [AW-1:0] ra_o,
  output logic          re_o,
  input  logic [DW-1:0] dout_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, ra_q;
  logic [AW:0]   rem_q, rem_d;
  logic          inflight_q, inflight_last_q;
  logic [DW-1:0] buf_q [2];
  logic [1:0]    last_q;
  logic          wp_q, rp_q;
  logic [1:0]    cnt_q;
  logic          pop, push, acc, is_last;
  assign cmd_ready_o = rstn_i && state_q == IDLE;
  assign out_valid_o = cnt_q != 2'd0;
  assign out_data_o  = buf_q[rp_q];
  assign out_last_o  = out_valid_o & last_q[rp_q];
  assign ra_o        = re_o ? addr_q : ra_q;
  assign pop         = out_valid_o & out_ready_i;
  assign push        = inflight_q;
  assign acc         = cmd_valid_i & cmd_ready_o;
  assign is_last     = rem_q == (AW+1)'(1);
  // A read is issued only if its word is guaranteed a buffer slot when it lands.
  assign re_o = state_q == RUN && rem_q != '0 &&
                int'(cnt_q) + int'(inflight_q) < BUF_DEPTH + int'(pop);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    if (acc) begin
      state_d = RUN;
      addr_d  = cmd_addr_i;
      rem_d   = cmd_len_i == '0 ? {1'b1, {AW{1'b0}}} : {1'b0, cmd_len_i};
    end
    if (re_o) begin
      addr_d  = addr_q + AW'(1);
      rem_d   = rem_q - (AW+1)'(1);
      state_d = is_last ? DRAIN : state_q;
    end
    if (state_q == DRAIN && cnt_q == 2'd0 && !inflight_q) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      ra_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      last_q          <= '0;
      wp_q            <= 1'b0;
      rp_q            <= 1'b0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= re_o;
      inflight_last_q <= re_o & is_last;
      if (re_o) ra_q <= addr_q;
      if (push) begin
        buf_q[wp_q]  <= dout_i;
        last_q[wp_q] <= inflight_last_q;
        wp_q         <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_sa_ram_rd_stream.sv
// tb_sa_ram_rd_stream: directed self-checking bench for sa_ram_rd_stream
module tb_sa_ram_rd_stream;
  logic        clk = 0, rstn = 0;
  logic        cmd_valid = 0, cmd_ready;
  logic [6:0]  cmd_addr = 0, cmd_len = 0, ra;
  logic        re, out_valid, out_ready = 0, out_last;
  logic [63:0] dout = 0, out_data;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] beats [$];
  logic        lasts [$];
  logic [6:0]  ra_log [$];
  int          beat_cyc [$];
  int          cyc = 0, m_cnt = 0;
  logic        m_inf = 0, hold = 0;
  logic [63:0] hold_data = 0;

  always #5 clk = ~clk;

  sa_ram_rd_stream dut (
    .clk_i(clk), .rstn_i(rstn), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .ra_o(ra), .re_o(re), .dout_i(dout),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last)
  );

  function automatic logic [63:0] mem_val(input int i);
    return 64'(i) * 64'h0101;
  endfunction

  always_ff @(posedge clk) if (re) dout <= mem_val(int'(ra));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: collects beats and read addresses, checks credit and stall stability from its own model.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      m_cnt = 0;
      m_inf = 0;
      hold  = 0;
    end else begin
      if (re) begin
        ra_log.push_back(ra);
        chk("credit", 64'(m_cnt + int'(m_inf) - int'(out_valid & out_ready) < 2), 64'd1);
      end
      if (hold) begin
        chk("stall_data", out_data, hold_data);
        chk("stall_valid", 64'(out_valid), 64'd1);
      end
      if (out_valid && out_ready) begin
        beats.push_back(out_data);
        lasts.push_back(out_last);
        beat_cyc.push_back(cyc);
      end
      hold      = out_valid & !out_ready;
      hold_data = out_data;
      m_cnt     = m_cnt + int'(m_inf) - int'(out_valid & out_ready);
      m_inf     = re;
    end
  end

  task automatic clear_logs();
    beats.delete();
    lasts.delete();
    ra_log.delete();
    beat_cyc.delete();
  endtask

  task automatic send(input logic [6:0] a, input logic [6:0] l);
    int i = 0;
    while (!cmd_ready && i < 300) begin
      @(posedge clk) #1;
      i++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_valid = 1;
    cmd_addr  = a;
    cmd_len   = l;
    @(posedge clk) #1;
    cmd_valid = 0;
  endtask

  task automatic wait_beats(input int n);
    int i = 0;
    while (beats.size() < n && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (beats.size() < n) chk("beat_timeout", 64'(beats.size()), 64'(n));
  endtask

  task automatic wait_idle();
    int i = 0;
    while (!cmd_ready && i < 300) begin
      @(posedge clk) #1;
      i++;
    end
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  task automatic chk_burst(input string tag, input int a, input int n);
    int nl = 0;
    chk({tag, "_count"}, 64'(beats.size()), 64'(n));
    for (int i = 0; i < beats.size(); i++) begin
      chk({tag, "_data"}, beats[i], mem_val((a + i) % 128));
      nl += int'(lasts[i]);
    end
    chk({tag, "_last_count"}, 64'(nl), 64'd1);
    if (beats.size() > 0) chk({tag, "_last_pos"}, 64'(lasts[beats.size()-1]), 64'd1);
  endtask

  logic [15:0] pat = 16'b1011_0100_1101_1001;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_re", 64'(re), 64'd0);
    chk("rst_ra", 64'(ra), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    rstn = 1;
    @(posedge clk) #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // 1: basic burst and latency
    clear_logs();
    out_ready = 1;
    send(7'd5, 7'd4);
    chk("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    chk("t1_re_T1", 64'(re), 64'd1);
    chk("t1_ra_T1", 64'(ra), 64'd5);
    @(negedge clk);
    chk("t1_valid_T1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid_T2", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid_T3", 64'(out_valid), 64'd1);
    chk("t1_data_T3", out_data, 64'h0505);
    wait_beats(4);
    wait_idle();
    chk_burst("t1", 5, 4);

    // 2: address wrap
    clear_logs();
    send(7'd126, 7'd4);
    wait_beats(4);
    wait_idle();
    chk("t2_ra_count", 64'(ra_log.size()), 64'd4);
    for (int i = 0; i < ra_log.size(); i++) chk("t2_ra", 64'(ra_log[i]), 64'((126 + i) % 128));
    chk_burst("t2", 126, 4);

    // 3: len 0 means 128 beats, contiguous
    clear_logs();
    send(7'd0, 7'd0);
    wait_beats(128);
    wait_idle();
    repeat (5) @(posedge clk);
    chk_burst("t3", 0, 128);
    if (beat_cyc.size() == 128) chk("t3_contiguous", 64'(beat_cyc[127] - beat_cyc[0]), 64'd127);

    // 4: pseudo-random backpressure
    clear_logs();
    out_ready = 0;
    send(7'd20, 7'd8);
    for (int k = 0; k < 200 && beats.size() < 8; k++) begin
      out_ready = pat[k % 16];
      @(posedge clk) #1;
    end
    out_ready = 1;
    wait_beats(8);
    wait_idle();
    chk_burst("t4", 20, 8);

    // 5: full stall from accept
    clear_logs();
    out_ready = 0;
    send(7'd40, 7'd8);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_re_pulses", 64'(ra_log.size()), 64'd2);
    chk("t5_re_stalled", 64'(re), 64'd0);
    chk("t5_no_beats", 64'(beats.size()), 64'd0);
    out_ready = 1;
    wait_beats(8);
    wait_idle();
    chk("t5_re_total", 64'(ra_log.size()), 64'd8);
    chk_burst("t5", 40, 8);

    // 6: mid-burst reset, then a single-beat burst
    clear_logs();
    send(7'd60, 7'd10);
    wait_beats(3);
    @(posedge clk) #1;
    rstn = 0;
    @(posedge clk) #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_re", 64'(re), 64'd0);
    chk("t6_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    rstn = 1;
    #1;
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    clear_logs();
    send(7'd0, 7'd1);
    wait_beats(1);
    wait_idle();
    repeat (5) @(posedge clk);
    chk_burst("t6", 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
